// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: acks every sampled req one cycle later and queues its payload
// for a valid/ready consumer. Define REQ_ACK_RESPONDER_ASSERT_EN to embed the handshake assertions.
module req_ack_responder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              overflow,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SC_W  = $clog2(STALL_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_STALLED = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_ack;
  logic                r_overflow;
  logic                r_stall;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [SC_W-1:0]     r_stall_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [SC_W-1:0]     w_stall_cnt_nxt;

  // Downstream handshake: the head transfers on a rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_data holds until that transfer happens.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && out_ready;
  assign w_push = req && (!w_full || w_pop);
  assign w_drop = req && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (w_pop)
      w_stall_cnt_nxt = '0;
    else if ((r_state == ST_PRESENT) && !out_ready && (r_stall_cnt != STALL_MAX))
      w_stall_cnt_nxt = r_stall_cnt + 1'b1;
  end

  // The ack path is deliberately independent of FIFO state: a dropped request is still acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ack <= req;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= req_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Head FSM follows the next count so PRESENT coincides with out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_count_nxt != '0)
            r_state <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (w_count_nxt == '0) begin
            r_state <= ST_IDLE;
          end else if (w_stall_cnt_nxt == STALL_MAX) begin
            r_state <= ST_STALLED;
            r_stall <= 1'b1;
          end
        end
        ST_STALLED: begin
          if (w_pop)
            r_state <= (w_count_nxt == '0) ? ST_IDLE : ST_PRESENT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign busy      = w_full;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign overflow  = r_overflow;
  assign stall     = r_stall;
  assign dbg_state = r_state;

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
  global clocking rar_gclk @(posedge clk); endclocking

  a_req_ack: assert property (@(rar_gclk) disable iff (rst) req |=> ack);
  a_no_spurious_ack: assert property (@(rar_gclk) disable iff (rst) !$past(req) |-> !ack);
  a_count_bound: assert property (@(rar_gclk) disable iff (rst) (r_count <= FULL_CNT));
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder: handshake, FIFO ordering, overflow, full push+pop,
// stall detection and asynchronous reset, each against hand-computed expectations.
module tb_req_ack_responder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req;
   logic [W-1:0] req_data;
   logic         ack;
   logic         busy;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic         overflow;
   logic         stall;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   req_ack_responder #(.DATA_W(W), .DEPTH(4), .STALL_LIMIT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .overflow  (overflow),
      .stall     (stall),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic push_one(input logic [W-1:0] d, input bit accepted);
      req      = 1'b1;
      req_data = d;
      step();
      if (accepted)
         exp_q.push_back(d);
      check("push_ack", ack, 1);
   endtask

   task automatic drain();
      logic [W-1:0] e;
      req       = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("drain_valid", out_valid, 1);
         check("drain_data", out_data, e);
         step();
      end
      check("drain_empty", out_valid, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req       = 1'b0;
      req_data  = '0;
      out_ready = 1'b0;
      #2;
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_ovf", overflow, 0);
      check("rst_stall", stall, 0);
      check("rst_state", dbg_state, 0);
      step();
      rst = 1'b0;
      step();

      // Single request with a ready consumer.
      out_ready = 1'b1;
      req       = 1'b1;
      req_data  = 8'hA5;
      step();
      check("single_ack", ack, 1);
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 8'hA5);
      req = 1'b0;
      step();
      check("single_ack_low", ack, 0);
      check("single_empty", out_valid, 0);
      check("single_state", dbg_state, 0);
      check("single_ovf", overflow, 0);
      check("single_stall", stall, 0);

      // Burst of four with the consumer stalled, then drained in order.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         push_one(W'(i), 1'b1);
         check("burst_busy", busy, (i == 4) ? 1 : 0);
         check("burst_head", out_data, 1);
      end
      req = 1'b0;
      step();
      check("burst_ack_low", ack, 0);
      check("burst_ovf", overflow, 0);
      drain();
      check("burst_busy_end", busy, 0);

      // Overflow: fifth request while full is acked but dropped.
      for (int i = 0; i < 4; i++)
         push_one(W'(8'h11 + i), 1'b1);
      push_one(8'h55, 1'b0);
      check("ovf_flag", overflow, 1);
      check("ovf_busy", busy, 1);
      drain();
      check("ovf_sticky", overflow, 1);

      // Full push+pop in the same cycle is accepted.
      do_reset();
      check("reset_clears_ovf", overflow, 0);
      for (int i = 5; i <= 8; i++)
         push_one(W'(i), 1'b1);
      out_ready = 1'b1;
      check("fpp_head", out_data, 5);
      void'(exp_q.pop_front());
      push_one(8'd9, 1'b1);
      check("fpp_busy", busy, 1);
      check("fpp_ovf", overflow, 0);
      check("fpp_head2", out_data, 6);
      drain();

      // Stall: one entry held for STALL_LIMIT cycles.
      out_ready = 1'b0;
      push_one(8'h3C, 1'b1);
      req = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 15) begin
            check("stall_pre", stall, 0);
            check("stall_pre_state", dbg_state, 1);
         end
      end
      check("stall_set", stall, 1);
      check("stall_state", dbg_state, 2);
      drain();
      check("stall_idle", dbg_state, 0);
      check("stall_sticky", stall, 1);

      // Reset mid-burst with ack high.
      out_ready = 1'b0;
      push_one(8'hA1, 1'b1);
      push_one(8'hA2, 1'b1);
      push_one(8'hA3, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_ack", ack, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_state", dbg_state, 0);
      req = 1'b0;
      step();
      rst = 1'b0;
      exp_q.delete();
      step();
      check("post_rst_ack_idle", ack, 0);
      push_one(8'h77, 1'b1);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_data", out_data, 8'h77);
      req = 1'b0;
      step();
      check("post_rst_ack_low", ack, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
